// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule constants and types.
// Imported by aes_subword_fwd and aes_invkey_sched.
package aes_pkg;

  localparam int unsigned NR = 10;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FWD,
    ST_EMIT
  } state_e;

  // Entry 0 is unused so RCON[r] is the constant for round r.
  localparam logic [7:0] RCON [0:10] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // Indices above the last round yield zero instead of reading past the table.
  function automatic logic [7:0] rcon_of(input logic [3:0] r);
    return (r > 4'd10) ? 8'h00 : RCON[r];
  endfunction

  function automatic word_t rot_word(input word_t x);
    return {x[23:0], x[31:24]};
  endfunction

endpackage

// File: rtl/aes_subword_fwd.sv
// Combinational forward S-box applied to all four bytes of a word.
// One instance serves both the forward and the inverse key steps.
module aes_subword_fwd
  import aes_pkg::*;
(
  input  word_t in_word,
  output word_t out_word
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,
    8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,
    8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,
    8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,
    8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,
    8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,
    8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,
    8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,
    8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,
    8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,
    8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,
    8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,
    8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,
    8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,
    8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,
    8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,
    8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  // Byte-wise table lookup, MSB byte first.
  always_comb begin
    out_word = {SBOX[in_word[31:24]],
                SBOX[in_word[23:16]],
                SBOX[in_word[15:8]],
                SBOX[in_word[7:0]]};
  end

endmodule

// File: rtl/aes_invkey_sched.sv
// AES-128 decryption key schedule: runs forward to round NR, then
// streams round keys NR..0 by inverting the recurrence one step per
// accepted key. Optional macro INVKEY_DIRECT_EN adds key_is_last so a
// round-NR key can be loaded directly, skipping the forward pass.
module aes_invkey_sched
  import aes_pkg::*;
#(
  parameter int unsigned NR = aes_pkg::NR
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [127:0] key,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_data,
  output logic [3:0]   rk_round,
  output logic         rk_last
`ifdef INVKEY_DIRECT_EN
  ,
  input  logic         key_is_last
`endif
);

  state_e       state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [3:0]   rnd_q, rnd_d;

  word_t w0, w1, w2, w3;
  word_t sb_in, sb_out;
  word_t n0, n1, n2, n3;
  word_t p0, p1, p2, p3;
  logic [7:0]   rc;
  logic         direct;

  assign w0 = key_q[127:96];
  assign w1 = key_q[95:64];
  assign w2 = key_q[63:32];
  assign w3 = key_q[31:0];

  // Select whether an accepted key skips the forward pass.
  always_comb begin
`ifdef INVKEY_DIRECT_EN
    direct = key_is_last;
`else
    direct = 1'b0;
`endif
  end

  aes_subword_fwd u_subword (
    .in_word  (rot_word(sb_in)),
    .out_word (sb_out)
  );

  // Shared S-box input and round constant chosen by phase; both steps.
  always_comb begin
    sb_in = w3;
    rc    = rcon_of(rnd_q + 4'd1);
    if (state_q == ST_EMIT) begin
      sb_in = w3 ^ w2;
      rc    = rcon_of(rnd_q);
    end
    n0 = w0 ^ sb_out ^ {rc, 24'h0};
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    n3 = w3 ^ n2;
    p3 = w3 ^ w2;
    p2 = w2 ^ w1;
    p1 = w1 ^ w0;
    p0 = w0 ^ sb_out ^ {rc, 24'h0};
  end

  // State, key and round registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      key_q   <= '0;
      rnd_q   <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      rnd_q   <= rnd_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (key_valid) begin
          state_d = direct ? ST_EMIT : ST_FWD;
        end
      end
      ST_FWD: begin
        if (rnd_q == 4'(NR - 1)) begin
          state_d = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (rk_ready && rnd_q == 4'd0) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Key register and round counter updates for each phase.
  always_comb begin
    key_d = key_q;
    rnd_d = rnd_q;
    unique case (state_q)
      ST_IDLE: begin
        if (key_valid) begin
          key_d = key;
          rnd_d = direct ? 4'(NR) : 4'd0;
        end
      end
      ST_FWD: begin
        key_d = {n0, n1, n2, n3};
        rnd_d = rnd_q + 4'd1;
      end
      ST_EMIT: begin
        if (rk_ready && rnd_q != 4'd0) begin
          key_d = {p0, p1, p2, p3};
          rnd_d = rnd_q - 4'd1;
        end
      end
      default: begin
        key_d = key_q;
        rnd_d = rnd_q;
      end
    endcase
  end

  // Outputs decoded from registers only.
  always_comb begin
    key_ready = (state_q == ST_IDLE);
    rk_valid  = (state_q == ST_EMIT);
    rk_data   = key_q;
    rk_round  = rnd_q;
    rk_last   = (state_q == ST_EMIT) && (rnd_q == 4'd0);
  end

endmodule

// File: tb/tb_aes_invkey_sched.sv
// Scoreboard bench for aes_invkey_sched using FIPS-197 and all-zero
// key schedules; a monitor checks every delivered round key.
module tb_aes_invkey_sched;

  logic         clk = 1'b0;
  logic         reset;
  logic         key_valid;
  logic         key_ready;
  logic [127:0] key;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] rk_data;
  logic [3:0]   rk_round;
  logic         rk_last;
  logic         key_is_last;

  typedef struct {
    logic [127:0] data;
    logic [3:0]   round;
    logic         last;
    int           due;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   edge_cnt = 0;
  bit   bp_mode = 1'b0;

  localparam logic [127:0] FIPS_RK [11] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };

  localparam logic [127:0] ZERO_RK [11] = '{
    128'h00000000000000000000000000000000,
    128'h62636363626363636263636362636363,
    128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa,
    128'h90973450696ccffaf2f457330b0fac99,
    128'hee06da7b876a1581759e42b27e91ee2b,
    128'h7f2e2b88f8443e098dda7cbbf34b9290,
    128'hec614b851425758c99ff09376ab49ba7,
    128'h217517873550620bacaf6b3cc61bf09b,
    128'h0ef903333ba9613897060a04511dfa9f,
    128'hb1d4d8e28a7db9da1d7bb3de4c664941,
    128'hb4ef5bcb3e92e21123e951cf6f8f188e
  };

  aes_invkey_sched dut (
    .clk         (clk),
    .reset       (reset),
    .key_valid   (key_valid),
    .key_ready   (key_ready),
    .key         (key),
    .rk_valid    (rk_valid),
    .rk_ready    (rk_ready),
    .rk_data     (rk_data),
    .rk_round    (rk_round),
    .rk_last     (rk_last)
`ifdef INVKEY_DIRECT_EN
    ,
    .key_is_last (key_is_last)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt++;

  task automatic check(input string name,
                       input logic [127:0] act,
                       input logic [127:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic logic [127:0] rk_of(input int sel, input int r);
    return (sel == 0) ? FIPS_RK[r] : ZERO_RK[r];
  endfunction

  task automatic push_stream(input int sel, input int due);
    for (int r = 10; r >= 0; r--) begin
      exp_t e;
      e.data  = rk_of(sel, r);
      e.round = 4'(r);
      e.last  = (r == 0);
      e.due   = (r == 10) ? due : -1;
      exp_q.push_back(e);
    end
  endtask

  // Present a key; hs returns the posedge count of the handshake edge.
  task automatic send_key(input logic [127:0] k, input int sel,
                          input bit direct, input bit hold,
                          output int hs);
    int cnt;
    cnt = 0;
    @(negedge clk);
    key_valid   = 1'b1;
    key         = k;
    key_is_last = direct;
    while (!key_ready && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    if (!key_ready) begin
      check("key_accept_timeout", 128'd0, 128'd1);
      key_valid = 1'b0;
      hs = -1;
      return;
    end
    hs = edge_cnt + 1;
    push_stream(sel, direct ? hs : hs + 10);
    @(negedge clk);
    if (!hold) begin
      key_valid   = 1'b0;
      key_is_last = 1'b0;
    end
  endtask

  task automatic drain;
    int cnt;
    cnt = 0;
    while (exp_q.size() != 0 && cnt < 400) begin
      @(negedge clk);
      cnt++;
    end
    check("drain_empty", 128'(exp_q.size()), 128'd0);
  endtask

  // Consumer-side ready: always high unless backpressure is enabled.
  initial begin
    rk_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      rk_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: pops the scoreboard on each round-key handshake.
  initial begin
    exp_t         e;
    logic         prev_valid;
    logic         prev_stall;
    logic         prev_cont;
    logic [127:0] pd;
    logic [3:0]   pr;
    prev_valid = 1'b0;
    prev_stall = 1'b0;
    prev_cont  = 1'b0;
    pd = '0;
    pr = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_valid = 1'b0;
        prev_stall = 1'b0;
        prev_cont  = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_valid", 128'(rk_valid), 128'd1);
          check("stall_data", rk_data, pd);
          check("stall_round", 128'(rk_round), 128'(pr));
        end
        if (prev_cont) begin
          check("no_bubble", 128'(rk_valid), 128'd1);
        end
        if (rk_valid && !prev_valid) begin
          if (exp_q.size() == 0) begin
            check("unexpected_valid", 128'd1, 128'd0);
          end else begin
            check("first_valid_cycle", 128'(edge_cnt),
                  128'(exp_q[0].due));
          end
        end
        prev_cont = 1'b0;
        if (rk_valid && rk_ready) begin
          if (exp_q.size() == 0) begin
            check("extra_key", 128'd1, 128'd0);
          end else begin
            e = exp_q.pop_front();
            check("rk_data", rk_data, e.data);
            check("rk_round", 128'(rk_round), 128'(e.round));
            check("rk_last", 128'(rk_last), 128'(e.last));
            prev_cont = !e.last;
          end
        end
        prev_valid = rk_valid;
        prev_stall = rk_valid && !rk_ready;
        pd = rk_data;
        pr = rk_round;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs1;
    int hs2;
    int cnt;
    reset       = 1'b1;
    key_valid   = 1'b0;
    key         = '0;
    key_is_last = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_rk_valid", 128'(rk_valid), 128'd0);
    check("reset_rk_data", rk_data, 128'd0);
    check("reset_rk_round", 128'(rk_round), 128'd0);
    check("reset_rk_last", 128'(rk_last), 128'd0);
    check("reset_key_ready", 128'(key_ready), 128'd1);

    send_key(FIPS_RK[0], 0, 1'b0, 1'b0, hs1);
    drain();

    bp_mode = 1'b1;
    send_key(FIPS_RK[0], 0, 1'b0, 1'b0, hs1);
    drain();
    bp_mode = 1'b0;
    repeat (2) @(negedge clk);

    send_key(FIPS_RK[0], 0, 1'b0, 1'b1, hs1);
    send_key(ZERO_RK[0], 1, 1'b0, 1'b0, hs2);
    check("back_to_back_accept", 128'(hs2), 128'(hs1 + 22));
    drain();

    send_key(FIPS_RK[0], 0, 1'b0, 1'b0, hs1);
    cnt = 0;
    while (!(rk_valid && rk_round == 4'd5) && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    check("reach_round5", 128'(rk_round), 128'd5);
    #1;
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("midreset_rk_valid", 128'(rk_valid), 128'd0);
    check("midreset_key_ready", 128'(key_ready), 128'd1);
    reset = 1'b0;
    send_key(ZERO_RK[0], 1, 1'b0, 1'b0, hs1);
    drain();

`ifdef INVKEY_DIRECT_EN
    send_key(FIPS_RK[10], 0, 1'b1, 1'b0, hs1);
    drain();
`endif

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
